// File: rtl/imm_decode_fifo_if.sv
// Handshake bundle between fetch/decode and the immediate decode FIFO.
interface imm_decode_fifo_if #(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned DEPTH = 2
);
  logic                      in_valid;
  logic                      in_ready;
  logic [31:0]               inst;
  logic                      out_valid;
  logic                      out_ready;
  logic [XLEN-1:0]           imm;
  logic [2:0]                fmt;
  logic                      illegal;
  logic [$clog2(DEPTH):0]    count;

  modport master (
    output in_valid, inst, out_ready,
    input  in_ready, out_valid, imm, fmt, illegal, count
  );

  modport slave (
    input  in_valid, inst, out_ready,
    output in_ready, out_valid, imm, fmt, illegal, count
  );
endinterface

// File: rtl/imm_decode_fifo.sv
// RV immediate decoder feeding a DEPTH-entry FIFO toward the operand mux.
// Define IMM_BYPASS_EN for a 0-cycle path through an empty FIFO.
module imm_decode_fifo #(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  imm_decode_fifo_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam bit          RV64 = (XLEN == 64);

  localparam logic [2:0] FMT_R   = 3'd0;
  localparam logic [2:0] FMT_I   = 3'd1;
  localparam logic [2:0] FMT_S   = 3'd2;
  localparam logic [2:0] FMT_B   = 3'd3;
  localparam logic [2:0] FMT_U   = 3'd4;
  localparam logic [2:0] FMT_J   = 3'd5;
  localparam logic [2:0] FMT_ILL = 3'd7;

  logic [31:0]     w_imm32;
  logic [XLEN-1:0] w_dec_imm;
  logic [2:0]      w_dec_fmt;
  logic            w_dec_ill;
  logic [31:0]     w_i;

  logic [XLEN-1:0] r_imm_mem [DEPTH];
  logic [2:0]      r_fmt_mem [DEPTH];
  logic            r_ill_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;

  logic w_empty;
  logic w_in_ready;
  logic w_push;
  logic w_push_store;
  logic w_pop;
  logic w_bypass;

  // Immediate extraction; every format builds a 32-bit value then sign-extends.
  assign w_i = bus.inst;
  always_comb begin
    w_imm32   = '0;
    w_dec_fmt = FMT_ILL;
    w_dec_ill = 1'b1;
    case (w_i[6:0])
      7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: begin
        w_dec_fmt = FMT_I;
        w_dec_ill = 1'b0;
        w_imm32   = {{20{w_i[31]}}, w_i[31:20]};
      end
      7'b0011011: begin
        if (RV64) begin
          w_dec_fmt = FMT_I;
          w_dec_ill = 1'b0;
          w_imm32   = {{20{w_i[31]}}, w_i[31:20]};
        end
      end
      7'b0100011: begin
        w_dec_fmt = FMT_S;
        w_dec_ill = 1'b0;
        w_imm32   = {{20{w_i[31]}}, w_i[31:25], w_i[11:7]};
      end
      7'b1100011: begin
        w_dec_fmt = FMT_B;
        w_dec_ill = 1'b0;
        w_imm32   = {{19{w_i[31]}}, w_i[31], w_i[7], w_i[30:25], w_i[11:8], 1'b0};
      end
      7'b0110111, 7'b0010111: begin
        w_dec_fmt = FMT_U;
        w_dec_ill = 1'b0;
        w_imm32   = {w_i[31:12], 12'b0};
      end
      7'b1101111: begin
        w_dec_fmt = FMT_J;
        w_dec_ill = 1'b0;
        w_imm32   = {{11{w_i[31]}}, w_i[31], w_i[19:12], w_i[20], w_i[30:21], 1'b0};
      end
      7'b0110011: begin
        w_dec_fmt = FMT_R;
        w_dec_ill = 1'b0;
      end
      7'b0111011: begin
        if (RV64) begin
          w_dec_fmt = FMT_R;
          w_dec_ill = 1'b0;
        end
      end
      default: ;
    endcase
  end
  assign w_dec_imm = XLEN'(signed'(w_imm32));

  assign w_empty    = (r_count == '0);
  assign w_in_ready = (r_count < CW'(DEPTH)) || bus.out_ready;
  assign w_push     = bus.in_valid && w_in_ready;
  assign w_pop      = !w_empty && bus.out_ready;

`ifdef IMM_BYPASS_EN
  assign w_bypass = w_empty && bus.in_valid;
`else
  assign w_bypass = 1'b0;
`endif
  // A bypassed entry taken by the consumer in the same cycle is never stored.
  assign w_push_store = w_push && !(w_bypass && bus.out_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_store) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)        r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_push_store && !w_pop)      r_count <= r_count + CW'(1);
      else if (!w_push_store && w_pop) r_count <= r_count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_store) begin
      r_imm_mem[r_wr_ptr] <= w_dec_imm;
      r_fmt_mem[r_wr_ptr] <= w_dec_fmt;
      r_ill_mem[r_wr_ptr] <= w_dec_ill;
    end
  end

  // Head view; zeros while empty so reset values need no storage reset.
  assign bus.in_ready  = w_in_ready;
  assign bus.count     = r_count;
  assign bus.out_valid = !w_empty || w_bypass;
  assign bus.imm       = w_bypass ? w_dec_imm : (w_empty ? '0 : r_imm_mem[r_rd_ptr]);
  assign bus.fmt       = w_bypass ? w_dec_fmt : (w_empty ? FMT_R : r_fmt_mem[r_rd_ptr]);
  assign bus.illegal   = w_bypass ? w_dec_ill : (w_empty ? 1'b0 : r_ill_mem[r_rd_ptr]);
endmodule

// File: doc/imm_decode_fifo.md
Name: imm_decode_fifo

Overview:
- Registered, parametrised successor to the combinational immediate decoder in the datapath.
- Accepts 32-bit RV instructions over a valid/ready handshake.
- Extracts and sign-extends the immediate to XLEN bits, classifies the format and flags unsupported opcodes.
- Buffers results in a DEPTH-entry FIFO between fetch/decode and the execute-stage operand mux.

Parameters:
- XLEN, 64, width of the immediate output (32 or 64).
- DEPTH, 2, number of FIFO entries (power of 2, >=2).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  instruction present.
- in_ready  output  1  block can accept an instruction this cycle.
- inst  input  32  instruction word.
- out_valid  output  1  head FIFO entry valid.
- out_ready  input  1  consumer takes head entry.
- imm  output  XLEN  sign-extended immediate of the head entry.
- fmt  output  3  format of the head entry: R=0, I=1, S=2, B=3, U=4, J=5, ILL=7.
- illegal  output  1  head entry opcode unsupported.
- count  output  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Reset: asynchronous on rst_n low. Clears pointers and count. out_valid=0, imm=0, fmt=0, illegal=0, count=0. Storage contents are don't-care. A reset asserted mid-transfer drops all entries; no partial entry survives.
- Decode is combinational on inst and is written into the tail entry when in_valid && in_ready.
- Opcode map (inst[6:0]):
  - I: 0010011, 0000011, 1100111, 1110011, plus 0011011 when XLEN=64. imm=sext(inst[31:20]).
  - S: 0100011. imm=sext({inst[31:25],inst[11:7]}).
  - B: 1100011. imm=sext({inst[31],inst[7],inst[30:25],inst[11:8],1'b0}).
  - U: 0110111, 0010111. imm=sext({inst[31:12],12'b0}).
  - J: 1101111. imm=sext({inst[31],inst[19:12],inst[20],inst[30:21],1'b0}).
  - R: 0110011, plus 0111011 when XLEN=64. imm=0, illegal=0.
  - Anything else: fmt=7, imm=0, illegal=1.
  - When XLEN=32, 0011011 and 0111011 are illegal.
- Sign extension always replicates inst[31] up to bit XLEN-1.
- Latency: an accepted instruction appears at the outputs on the next rising edge at the earliest (1 cycle when the FIFO is empty).
- Outputs are driven from the head entry only. Values are held stable while out_valid && !out_ready.
- Handshake:
  - in_ready = (count < DEPTH) || out_ready. Pop-through on full is allowed.
  - Push and pop in the same cycle leave count unchanged; both pointers advance.
  - Push when full without a simultaneous pop cannot occur, because in_ready=0.
  - Pop when empty is ignored (out_valid=0).
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. count tracks occupancy 0..DEPTH.
- in_valid may drop without a transfer; there is no requirement to hold inst stable.

Optional Feature:
- IMM_BYPASS_EN defined: when the FIFO is empty and in_valid=1, the outputs present the combinationally decoded entry in the same cycle (out_valid=1, 0-cycle latency).
  - If out_ready=1 in that cycle, the entry is consumed and not stored.
  - Otherwise it is stored normally.
  - in_ready and count are unaffected by the bypass path.
- Not defined: strict 1-cycle registered latency, and no combinational path from inst to outputs.

Test Plan:
- Reset, then push beq inst {1,111111,00000,00000,000,0110,1,1100011} with out_ready=1 -> next cycle out_valid=1, imm=-20, fmt=3, illegal=0.
- Push back-to-back addi 50 ({12'd50,5'd4,000,5'd5,0010011}) and sw 18(x0) ({7'b0,5'd4,5'd0,010,10010,0100011}) -> imm=50 fmt=1, then imm=18 fmt=2, in order.
- Push 32'h3A4000EF, 32'h00800067, 32'h00001297 -> imm=932 fmt=5; imm=8 fmt=1; imm=4096 fmt=4.
- Hold out_ready=0 and push DEPTH instructions -> count=DEPTH, in_ready=0. Assert out_ready with in_valid=1 -> simultaneous push/pop, count stays DEPTH, FIFO order preserved across pointer wrap.
- inst=32'h0000007F (opcode 1111111), plus 32'h0000003B with XLEN=32 -> fmt=7, illegal=1, imm=0. With XLEN=64, 0x3B -> fmt=0, illegal=0.
- Drop rst_n low asynchronously with 2 entries queued -> out_valid=0 and count=0 immediately, without waiting for a clock edge. After release, the next push decodes correctly.
